relu_maxpool2x2: RTL and testbench
==================================

Name: relu_maxpool2x2

Overview:
- Downstream stage of the 3x3 RGB convolution: consumes its raster-order 16-bit output stream (data_out/data_out_en).
- Applies ReLU and an optional right-shift requantisation, then 2x2 stride-2 max pooling.
- Emits one pooled pixel per 2x2 window, with row and frame markers, to the next layer.
- A single half-width line buffer holds the row-pair partial maxima.

Parameters:
- IMG_W, 640: input pixels per row; must be even and >= 2; an odd value is an elaboration error.
- IMG_H, 480: input rows per frame; must be >= 2.
- DATA_W, 16: input and output pixel width.
- SIGNED_IN, 0: 1 = din is two's complement; 0 = din is unsigned.
- SHIFT, 0: arithmetic right shift applied after ReLU; range 0..DATA_W-1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  input pixel (the convolution result).
- din_en  in  1  din is valid this cycle.
- din_sof  in  1  marks the first pixel of a frame; qualified by din_en.
- dout  out  DATA_W  pooled pixel.
- dout_en  out  1  dout is valid this cycle.
- dout_eol  out  1  last pooled pixel of an output row; qualified by dout_en.
- dout_eof  out  1  last pooled pixel of the frame; qualified by dout_en.
- sof_err  out  1  one-cycle pulse: din_sof arrived while a frame was incomplete.

Behaviour:
- Reset:
  - dout=0; dout_en, dout_eol, dout_eof and sof_err are 0.
  - col=0, row=0, h_prev=0.
  - Line buffer contents are don't-care.
- Stall: with din_en=0, no counters, registers or buffer change. dout_en, dout_eol, dout_eof and sof_err are driven 0 the next cycle.
- Pre-process (combinational on an accepted pixel):
  - v = 0 if SIGNED_IN=1 and din[DATA_W-1]=1.
  - Otherwise v = din >> SHIFT (logical shift; the value is non-negative after ReLU).
- Counters, advanced per accepted pixel:
  - col counts 0..IMG_W-1; at IMG_W-1 it wraps to 0 and row increments.
  - row counts 0..IMG_H-1; after the last pixel of row IMG_H-1, both counters are 0.
- Horizontal pair:
  - Even col: h_prev <= v.
  - Odd col: hmax = max(h_prev, v), unsigned compare.
- Vertical pair, line buffer of depth IMG_W/2 at address col>>1:
  - Even row, odd col: write hmax.
  - Odd row, even col: issue a registered read, so the data is available at the following odd col.
  - Odd row, odd col: dout <= max(buf_rd, hmax) and dout_en <= 1.
- Latency: dout_en is high exactly one clk after the edge that accepted the odd-row/odd-col pixel.
- Output rate: at most one output per two accepted pixels, so there is no backpressure and no overflow.
- Markers:
  - dout_eol=1 with the output for col=IMG_W-1.
  - dout_eof=1 with the output for col=IMG_W-1 and row=IMG_H-1 (or row IMG_H-2 when IMG_H is odd).
- Odd IMG_H: the last input row is accepted and counted but produces no output. Its buffer writes are harmless.
- Frame resync (din_en=1 and din_sof=1):
  - The pixel is treated as col=0, row=0.
  - If the counters were not both 0, sof_err pulses for 1 cycle the next cycle; the partial frame is discarded with no flush output.
  - din_sof with the counters already at 0 is normal and gives no error.
- Pixels before the first din_sof after reset are processed from col=0, row=0 (the counters are already 0).
- Reset mid-frame: the async clear takes effect immediately; outputs drop to 0 within the same cycle.
- Widths: max() results are DATA_W bits. No saturation is needed because the shift only reduces values.

Decomposition:
- Package relu_pool_pkg:
  - function umax(a, b).
  - Localparams BUF_DEPTH=IMG_W/2 and BUF_AW=$clog2(BUF_DEPTH), with a floor of 1.
  - Elaboration checks for IMG_W even and the SHIFT range.
- Sub-module pool_line_buf: simple dual-port RAM with one write port and one read port, synchronous read, 1-cycle latency, depth BUF_DEPTH, width DATA_W, no reset on the array.

Test Plan:
- Basic pooling: IMG_W=4, IMG_H=4, SHIFT=0, din 1..16 continuous with din_sof on pixel 1.
  - Outputs 6, 8, 14, 16.
  - eol on 8 and 16; eof on 16.
  - Each output 1 clk after pixels 6, 8, 14, 16 respectively.
- ReLU and shift: SIGNED_IN=1, SHIFT=2, 4x2 frame din = {-5, 8, 3, -1, 12, -7, 0, 20}.
  - Outputs 3 (12>>2) and 5 (20>>2).
  - Repeat with SIGNED_IN=0: -5 is taken as 0xFFFB, so the first output is 0x3FFE.
- Stalls: the basic-pooling frame with din_en low on random cycles (including between the even/odd pair and across the row boundary) gives identical values and markers.
- Mid-frame resync: din_sof reasserted at pixel 7 of a 4x4 frame.
  - sof_err pulses once.
  - Outputs before pixel 7 are unaffected; no output appears for the aborted frame.
  - The new frame produces 6, 8, 14, 16, relative to its own first pixel.
- Odd height: IMG_H=3, IMG_W=4, pixels 1..12.
  - Outputs 6 and 8 only, eof on 8.
  - Row 3 produces nothing; the next frame pools correctly.
- Reset mid-frame: rst_n pulsed low after pixel 5.
  - Outputs are 0 immediately.
  - The next frame starting with din_sof produces the correct values, and sof_err stays 0.

Source files
------------

// File: rtl/relu_pool_pkg.sv
// Shared helpers for the ReLU + 2x2 max-pool stage: unsigned max, buffer sizing
// and parameter sanity functions used at elaboration.
package relu_pool_pkg;

  // Widest pixel the shared max helper handles; callers cast in and out.
  localparam int UMAX_W = 64;

  function automatic logic [UMAX_W-1:0] umax(input logic [UMAX_W-1:0] a,
                                             input logic [UMAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The line buffer holds one horizontal maximum per pixel pair.
  function automatic int buf_depth(input int img_w);
    return img_w / 2;
  endfunction

  function automatic int buf_aw(input int img_w);
    return cnt_w(img_w / 2);
  endfunction

  function automatic bit img_w_ok(input int img_w);
    return (img_w >= 2) && (img_w % 2 == 0);
  endfunction

  function automatic bit shift_ok(input int shift, input int data_w);
    return (shift >= 0) && (shift < data_w);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port,
// one cycle read latency.
module pool_line_buf #(
  parameter int DEPTH  = 320,
  parameter int AW     = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every location is
  // written in an even row before the odd row reads it. Sequential state uses
  // non-blocking assignments so read and write see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU + optional right-shift requantisation followed by 2x2 stride-2 max
// pooling of a raster-order pixel stream, with row/frame markers.
module relu_maxpool2x2
  import relu_pool_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int DATA_W    = 16,
  parameter int SIGNED_IN = 0,
  parameter int SHIFT     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_en,
  input  logic              din_sof,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  output logic              dout_eol,
  output logic              dout_eof,
  output logic              sof_err
);

  localparam int BUF_DEPTH = buf_depth(IMG_W);
  localparam int BUF_AW    = buf_aw(IMG_W);
  localparam int COL_W     = cnt_w(IMG_W);
  localparam int ROW_W     = cnt_w(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  // With an odd height the final input row has no partner and never pools.
  localparam logic [ROW_W-1:0] ROW_LAST_OUT =
    ROW_W'((IMG_H % 2 == 0) ? IMG_H - 1 : IMG_H - 2);

  if (!img_w_ok(IMG_W)) begin : g_chk_img_w
    $error("relu_maxpool2x2: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2) begin : g_chk_img_h
    $error("relu_maxpool2x2: IMG_H must be >= 2");
  end
  if (!shift_ok(SHIFT, DATA_W)) begin : g_chk_shift
    $error("relu_maxpool2x2: SHIFT must be in 0..DATA_W-1");
  end
  if (DATA_W > UMAX_W) begin : g_chk_data_w
    $error("relu_maxpool2x2: DATA_W exceeds the umax helper width");
  end

  logic [COL_W-1:0]  col, col_eff, col_nxt;
  logic [ROW_W-1:0]  row, row_eff, row_nxt;
  logic [DATA_W-1:0] v, h_prev, hmax, buf_rd, pooled;
  logic              odd_col, odd_row;
  logic              buf_wr_en, buf_rd_en;
  logic [BUF_AW-1:0] buf_addr;

  // A start-of-frame pixel always lands at the origin, whatever the counters say.
  assign col_eff = din_sof ? '0 : col;
  assign row_eff = din_sof ? '0 : row;
  assign odd_col = col_eff[0];
  assign odd_row = row_eff[0];

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    v       = din >> SHIFT;
    col_nxt = col_eff + COL_W'(1);
    row_nxt = row_eff;
    if ((SIGNED_IN != 0) && din[DATA_W-1]) v = '0;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
    end
  end

  assign hmax   = DATA_W'(umax(UMAX_W'(h_prev), UMAX_W'(v)));
  assign pooled = DATA_W'(umax(UMAX_W'(buf_rd), UMAX_W'(hmax)));

  // Even rows park their horizontal maxima; odd rows prefetch on the even
  // column so the partner is ready when the odd column completes the window.
  assign buf_wr_en = din_en && !odd_row && odd_col;
  assign buf_rd_en = din_en && odd_row && !odd_col;
  assign buf_addr  = BUF_AW'(col_eff >> 1);

  pool_line_buf #(
    .DEPTH  (BUF_DEPTH),
    .AW     (BUF_AW),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_addr),
    .wr_data (hmax),
    .rd_en   (buf_rd_en),
    .rd_addr (buf_addr),
    .rd_data (buf_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      h_prev   <= '0;
      dout     <= '0;
      dout_en  <= 1'b0;
      dout_eol <= 1'b0;
      dout_eof <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      dout_en  <= 1'b0;
      dout_eol <= 1'b0;
      dout_eof <= 1'b0;
      sof_err  <= 1'b0;
      if (din_en) begin
        col     <= col_nxt;
        row     <= row_nxt;
        sof_err <= din_sof && ((col != '0) || (row != '0));
        if (!odd_col) h_prev <= v;
        if (odd_row && odd_col) begin
          dout     <= pooled;
          dout_en  <= 1'b1;
          dout_eol <= (col_eff == COL_LAST);
          dout_eof <= (col_eff == COL_LAST) && (row_eff == ROW_LAST_OUT);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench: several configurations of relu_maxpool2x2 share one stimulus
// bus; a frame-level reference model predicts outputs and per-DUT monitors check them.
module tb_relu_maxpool2x2;

  localparam int NCFG = 5;
  localparam int CW  [NCFG] = '{4, 4, 4, 4, 6};
  localparam int CH  [NCFG] = '{4, 2, 2, 3, 5};
  localparam int CS  [NCFG] = '{0, 1, 0, 0, 1};
  localparam int CSH [NCFG] = '{0, 2, 2, 0, 3};

  typedef struct {
    logic [15:0] val;
    logic        eol;
    logic        eof;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] din;
  logic den, din_sof;
  int sel;

  logic [NCFG-1:0][15:0] dout_w;
  logic [NCFG-1:0]       dout_en_w, eol_w, eof_w, err_w;

  exp_t        exp_q [NCFG][$];
  int unsigned err_q [NCFG][$];
  logic [15:0] frm   [NCFG][$];

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    relu_maxpool2x2 #(
      .IMG_W     (CW[g]),
      .IMG_H     (CH[g]),
      .DATA_W    (16),
      .SIGNED_IN (CS[g]),
      .SHIFT     (CSH[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_en   (den && (sel == g)),
      .din_sof  (din_sof),
      .dout     (dout_w[g]),
      .dout_en  (dout_en_w[g]),
      .dout_eol (eol_w[g]),
      .dout_eof (eof_w[g]),
      .sof_err  (err_w[g])
    );

    exp_t e;
    int unsigned ec;
    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (dout_en_w[g]) begin
          check($sformatf("cfg%0d output expected", g), 64'(exp_q[g].size() != 0), 64'(1));
          if (exp_q[g].size() != 0) begin
            e = exp_q[g].pop_front();
            check($sformatf("cfg%0d dout", g), 64'(dout_w[g]), 64'(e.val));
            check($sformatf("cfg%0d eol", g), 64'(eol_w[g]), 64'(e.eol));
            check($sformatf("cfg%0d eof", g), 64'(eof_w[g]), 64'(e.eof));
            check($sformatf("cfg%0d out cycle", g), 64'(cyc), 64'(e.cyc));
          end
        end
        if (err_w[g]) begin
          check($sformatf("cfg%0d sof_err expected", g), 64'(err_q[g].size() != 0), 64'(1));
          if (err_q[g].size() != 0) begin
            ec = err_q[g].pop_front();
            check($sformatf("cfg%0d sof_err cycle", g), 64'(cyc), 64'(ec));
          end
        end
      end
    end
  end

  // Reference: ReLU/shift one pixel.
  function automatic int relu(input int g, input logic [15:0] x);
    if (CS[g] != 0 && $signed(x) < 0) return 0;
    return int'(x >> CSH[g]);
  endfunction

  // Reference model: keep the current frame as a flat pixel list and pool
  // whenever a pixel closes a 2x2 window.
  task automatic model_accept(input int g, input logic [15:0] x, input logic sof);
    int idx, r, c, w, m;
    int win [4];
    exp_t e;
    w = CW[g];
    if (sof) begin
      if (frm[g].size() != 0) err_q[g].push_back(cyc + 1);
      frm[g].delete();
    end
    frm[g].push_back(x);
    idx = frm[g].size() - 1;
    r = idx / w;
    c = idx % w;
    if (r % 2 == 1 && c % 2 == 1) begin
      win[0] = relu(g, frm[g][idx]);
      win[1] = relu(g, frm[g][idx-1]);
      win[2] = relu(g, frm[g][idx-w]);
      win[3] = relu(g, frm[g][idx-w-1]);
      m = 0;
      foreach (win[k]) if (win[k] > m) m = win[k];
      e.val = 16'(m);
      e.eol = (c == w - 1);
      e.eof = e.eol && (r + 2 >= CH[g]);
      e.cyc = cyc + 1;
      exp_q[g].push_back(e);
    end
    if (frm[g].size() == w * CH[g]) frm[g].delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      den     = 1'b0;
      din     = 16'($urandom);
      din_sof = 1'($urandom);
    end
  endtask

  task automatic send(input int g, input logic [15:0] x, input logic sof, input int max_idle);
    int n;
    n = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
    idle(n);
    @(negedge clk);
    sel     = g;
    din     = x;
    din_sof = sof;
    den     = 1'b1;
    model_accept(g, x, sof);
  endtask

  task automatic ramp(input int g, input int n, input int max_idle);
    for (int i = 0; i < n; i++) send(g, 16'(i + 1), i == 0, max_idle);
  endtask

  task automatic rand_frame(input int g, input int max_idle);
    for (int i = 0; i < CW[g] * CH[g]; i++) send(g, 16'($urandom), i == 0, max_idle);
  endtask

  logic [15:0] sv_px [8] = '{16'hFFFB, 16'd8, 16'd3, 16'hFFFF, 16'd12, 16'hFFF9, 16'd0, 16'd20};

  initial begin
    rst_n   = 1'b0;
    den     = 1'b0;
    din     = '0;
    din_sof = 1'b0;
    sel     = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("cfg%0d reset dout", g), 64'(dout_w[g]), 64'(0));
      check($sformatf("cfg%0d reset dout_en", g), 64'(dout_en_w[g]), 64'(0));
      check($sformatf("cfg%0d reset eol", g), 64'(eol_w[g]), 64'(0));
      check($sformatf("cfg%0d reset eof", g), 64'(eof_w[g]), 64'(0));
      check($sformatf("cfg%0d reset sof_err", g), 64'(err_w[g]), 64'(0));
    end
    rst_n = 1'b1;
    idle(2);

    // Basic pooling, back to back.
    ramp(0, 16, 0);
    idle(3);
    // ReLU + shift, signed and unsigned interpretation.
    for (int i = 0; i < 8; i++) send(1, sv_px[i], i == 0, 0);
    for (int i = 0; i < 8; i++) send(2, sv_px[i], i == 0, 0);
    idle(3);
    // Same basic frame with random stalls.
    ramp(0, 16, 2);
    idle(3);
    // Mid-frame resync at pixel 7.
    ramp(0, 6, 0);
    ramp(0, 16, 0);
    idle(3);
    // Odd height, then a second frame to confirm it pools correctly.
    ramp(3, 12, 0);
    rand_frame(3, 1);
    idle(3);

    // Reset mid-frame after pixel 5 of a frame.
    ramp(0, 16, 0);
    ramp(0, 5, 0);
    @(negedge clk);
    den = 1'b0;
    check("cfg0 dout before reset", 64'(dout_w[0]), 64'(16));
    #2 rst_n = 1'b0;
    #1;
    check("cfg0 dout in reset", 64'(dout_w[0]), 64'(0));
    check("cfg0 dout_en in reset", 64'(dout_en_w[0]), 64'(0));
    for (int g = 0; g < NCFG; g++) frm[g].delete();
    idle(2);
    rst_n = 1'b1;
    ramp(0, 16, 1);
    idle(3);

    // Randomised frames across configurations.
    for (int f = 0; f < 3; f++) rand_frame(4, 2);
    for (int f = 0; f < 2; f++) rand_frame(1, 1);
    for (int f = 0; f < 2; f++) rand_frame(0, 2);
    idle(6);

    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("cfg%0d outputs left", g), 64'(exp_q[g].size()), 64'(0));
      check($sformatf("cfg%0d sof_err left", g), 64'(err_q[g].size()), 64'(0));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
